sig_monitor: RTL and testbench

SIG_MONITOR -- requirements
Module: sig_monitor

---
 rtl/sig_monitor_pkg.sv | 29 ++
 rtl/sig_monitor_crc32.sv | 30 +++
 rtl/sig_monitor.sv | 212 +++++++++++++++++++++
 tb/tb_sig_monitor.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sig_monitor_pkg.sv
// Shared definitions for the signature monitor: FSM state encoding, default
// mailbox addresses and CRC-32 constants.
package sig_monitor_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_ARMED   = 3'd1;
  localparam state_t ST_CAPTURE = 3'd2;
  localparam state_t ST_DRAIN   = 3'd3;
  localparam state_t ST_DONE    = 3'd4;

  localparam logic [31:0] DEF_BEGIN_ADDR = 32'h0000_0508;
  localparam logic [31:0] DEF_END_ADDR   = 32'h0000_050C;
  localparam logic [31:0] DEF_HALT_ADDR  = 32'h0000_0600;

  localparam logic [31:0] CRC_POLY   = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_INIT   = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_XOROUT = 32'hFFFF_FFFF;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/sig_monitor_crc32.sv
// Reflected CRC-32 update over one 32-bit word, LSB first.
// Present only when SIG_MONITOR_CRC_EN is defined.
`ifdef SIG_MONITOR_CRC_EN
module sig_monitor_crc32
  import sig_monitor_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [31:0] data,
  output logic [31:0] crc_out
);

  localparam logic [31:0] POLY_REFL = reflect32(CRC_POLY);

  logic [31:0] c_s;

  // Bit-serial shift unrolled over the full word
  always_comb begin
    c_s = crc_in;
    for (int i = 0; i < 32; i++) begin
      if (c_s[0] ^ data[i]) begin
        c_s = (c_s >> 1) ^ POLY_REFL;
      end else begin
        c_s = c_s >> 1;
      end
    end
    crc_out = c_s;
  end

endmodule
`endif

// File: rtl/sig_monitor.sv
// Snoops data-memory writes into a signature buffer and streams it out after halt.
// Optional CRC-32 output (crc_out) when SIG_MONITOR_CRC_EN is defined.
module sig_monitor
  import sig_monitor_pkg::*;
#(
  parameter int             AW         = 32,
  parameter int             DW         = 32,
  parameter int             DEPTH      = 64,
  parameter logic [AW-1:0]  BEGIN_ADDR = AW'(DEF_BEGIN_ADDR),
  parameter logic [AW-1:0]  END_ADDR   = AW'(DEF_END_ADDR),
  parameter logic [AW-1:0]  HALT_ADDR  = AW'(DEF_HALT_ADDR)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         snoop_we,
  input  logic [AW-1:0]                snoop_addr,
  input  logic [DW-1:0]                snoop_wdat,
  output logic                         sig_valid,
  input  logic                         sig_ready,
  output logic [DW-1:0]                sig_data,
  output logic                         sig_last,
  output logic                         done,
  output logic                         overflow,
  output logic [$clog2(DEPTH+1)-1:0]   sig_count
`ifdef SIG_MONITOR_CRC_EN
  ,
  output logic [31:0]                  crc_out
`endif
);

  localparam int            CW      = $clog2(DEPTH+1);
  localparam int            IW      = $clog2(DEPTH);
  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [IW-1:0] ONE_I   = IW'(1);

  state_t          state_r;
  logic [AW-1:0]   begin_r;
  logic [AW-1:0]   end_r;
  logic [CW-1:0]   count_r;
  logic            overflow_r;
  logic            done_r;
  logic            sig_valid_r;
  logic            sig_last_r;
  logic [DW-1:0]   sig_data_r;
  logic [IW-1:0]   k_r;
  logic [DEPTH-1:0] valid_r;
  logic [DW-1:0]   mem_r [DEPTH];

  logic            wr_begin_s, wr_end_s, wr_halt_s;
  logic [AW-1:0]   wdat_a_s, diff_s, words_s, off_s, cap_idx_s;
  logic            cap_hit_s, cap_ok_s;
  logic [CW-1:0]   count_calc_s;
  logic [IW-1:0]   nxt_k_s, rd_idx_s;
  logic [DW-1:0]   rd_data_s;

  assign wr_begin_s = snoop_we && (snoop_addr == BEGIN_ADDR);
  assign wr_end_s   = snoop_we && (snoop_addr == END_ADDR);
  assign wr_halt_s  = snoop_we && (snoop_addr == HALT_ADDR);
  assign wdat_a_s   = AW'(snoop_wdat);
  assign diff_s     = wdat_a_s - begin_r;
  assign words_s    = diff_s >> 2;
  assign off_s      = snoop_addr - begin_r;
  assign cap_idx_s  = off_s >> 2;
  assign cap_ok_s   = cap_idx_s < DEPTH_A;
  assign nxt_k_s    = k_r + ONE_I;

  // Mailbox addresses never count as capture, even inside [begin,end)
  assign cap_hit_s = (state_r == ST_CAPTURE) && snoop_we && !wr_halt_s && !wr_begin_s &&
                     !wr_end_s && (snoop_addr >= begin_r) && (snoop_addr < end_r) &&
                     (snoop_addr[1:0] == 2'b00);

  // Number of words the drain will emit, from the end pointer being written
  always_comb begin
    if (wdat_a_s <= begin_r) begin
      count_calc_s = '0;
    end else if (words_s >= DEPTH_A) begin
      count_calc_s = DEPTH_C;
    end else begin
      count_calc_s = words_s[CW-1:0];
    end
  end

  // Buffer readout, masked by valid bits; word 0 at drain start, k+1 while draining
  always_comb begin
    rd_idx_s = (state_r == ST_DRAIN) ? nxt_k_s : '0;
    if (valid_r[rd_idx_s]) begin
      rd_data_s = mem_r[rd_idx_s];
    end else begin
      rd_data_s = '0;
    end
  end

  // Signature buffer storage (unreset; valid bits gate readout)
  always_ff @(posedge clk) begin
    if (cap_hit_s && cap_ok_s) begin
      mem_r[cap_idx_s[IW-1:0]] <= snoop_wdat;
    end
  end

  // Control FSM, capture bookkeeping and output stream registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      begin_r     <= '0;
      end_r       <= '0;
      count_r     <= '0;
      overflow_r  <= 1'b0;
      done_r      <= 1'b0;
      sig_valid_r <= 1'b0;
      sig_last_r  <= 1'b0;
      sig_data_r  <= '0;
      k_r         <= '0;
      valid_r     <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (wr_halt_s) begin
            state_r <= ST_DRAIN;
            count_r <= '0;
          end else if (wr_begin_s) begin
            begin_r <= wdat_a_s;
            state_r <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (wr_halt_s) begin
            state_r <= ST_DRAIN;
            count_r <= '0;
          end else if (wr_end_s) begin
            end_r   <= wdat_a_s;
            count_r <= count_calc_s;
            valid_r <= '0;
            state_r <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (wr_halt_s) begin
            state_r <= ST_DRAIN;
            if (count_r != '0) begin
              sig_valid_r <= 1'b1;
              sig_data_r  <= rd_data_s;
              sig_last_r  <= (count_r == ONE_C);
              k_r         <= '0;
            end
          end else if (cap_hit_s) begin
            if (cap_ok_s) begin
              valid_r[cap_idx_s[IW-1:0]] <= 1'b1;
            end else begin
              overflow_r <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (!sig_valid_r) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end else if (sig_ready) begin
            if (sig_last_r) begin
              state_r     <= ST_DONE;
              done_r      <= 1'b1;
              sig_valid_r <= 1'b0;
              sig_last_r  <= 1'b0;
              sig_data_r  <= '0;
            end else begin
              k_r        <= nxt_k_s;
              sig_data_r <= rd_data_s;
              sig_last_r <= (CW'(nxt_k_s) == (count_r - ONE_C));
            end
          end
        end
        ST_DONE: begin
          state_r <= ST_DONE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign sig_valid = sig_valid_r;
  assign sig_data  = sig_data_r;
  assign sig_last  = sig_last_r;
  assign done      = done_r;
  assign overflow  = overflow_r;
  assign sig_count = count_r;

`ifdef SIG_MONITOR_CRC_EN
  logic [31:0] crc_r;
  logic [31:0] crc_next_s;

  sig_monitor_crc32 u_crc (
    .crc_in  (crc_r ^ CRC_XOROUT),
    .data    (sig_data_r[31:0]),
    .crc_out (crc_next_s)
  );

  // Running CRC kept in its final-xored form so reset reads as 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_r <= CRC_INIT ^ CRC_XOROUT;
    end else if ((state_r == ST_DRAIN) && sig_valid_r && sig_ready) begin
      crc_r <= crc_next_s ^ CRC_XOROUT;
    end
  end

  assign crc_out = crc_r;
`endif

endmodule

// File: tb/tb_sig_monitor.sv
// Randomized self-checking bench for sig_monitor against a word-map reference model.
module tb_sig_monitor;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BEGIN_A = 32'h0000_0508;
  localparam logic [31:0] END_A   = 32'h0000_050C;
  localparam logic [31:0] HALT_A  = 32'h0000_0600;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        snoop_we;
  logic [31:0] snoop_addr;
  logic [31:0] snoop_wdat;
  logic        sig_valid;
  logic        sig_ready;
  logic [31:0] sig_data;
  logic        sig_last;
  logic        done;
  logic        overflow;
  logic [6:0]  sig_count;
`ifdef SIG_MONITOR_CRC_EN
  logic [31:0] crc_out;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model: phase 0 idle, 1 armed, 2 capture, 3 halted
  int          m_phase;
  longint      m_begin, m_end;
  int          m_count;
  bit          m_ovf;
  logic [31:0] m_mem [int];
  logic [31:0] got_q [$];

  sig_monitor #(.AW(32), .DW(32), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .snoop_we   (snoop_we),
    .snoop_addr (snoop_addr),
    .snoop_wdat (snoop_wdat),
    .sig_valid  (sig_valid),
    .sig_ready  (sig_ready),
    .sig_data   (sig_data),
    .sig_last   (sig_last),
    .done       (done),
    .overflow   (overflow),
    .sig_count  (sig_count)
`ifdef SIG_MONITOR_CRC_EN
    ,
    .crc_out    (crc_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

`ifdef SIG_MONITOR_CRC_EN
  function automatic logic [31:0] crc_golden();
    logic [31:0] c = 32'hFFFF_FFFF;
    foreach (got_q[w]) begin
      for (int j = 0; j < 4; j++) begin
        c = c ^ {24'h0, got_q[w][8*j +: 8]};
        for (int b = 0; b < 8; b++) begin
          c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
      end
    end
    return c ^ 32'hFFFF_FFFF;
  endfunction
`endif

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ".valid"}, sig_valid, 1'b0);
    check_eq({tag, ".last"},  sig_last, 1'b0);
    check_eq({tag, ".data"},  sig_data, 32'h0);
    check_eq({tag, ".done"},  done, 1'b0);
    check_eq({tag, ".ovf"},   overflow, 1'b0);
    check_eq({tag, ".count"}, sig_count, 7'd0);
`ifdef SIG_MONITOR_CRC_EN
    check_eq({tag, ".crc"},   crc_out, 32'h0);
`endif
  endtask

  task automatic model_clear();
    m_phase = 0;
    m_ovf   = 1'b0;
    m_count = 0;
    m_mem.delete();
    got_q.delete();
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    snoop_we = 1'b0;
    sig_ready = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    check_reset_outputs(tag);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    longint la, ld, w;
    @(negedge clk);
    snoop_we = 1'b1;
    snoop_addr = a;
    snoop_wdat = d;
    la = longint'(a);
    ld = longint'(d);
    case (m_phase)
      0: if (a == HALT_A) begin m_phase = 3; m_count = 0; end
         else if (a == BEGIN_A) begin m_begin = ld; m_phase = 1; end
      1: if (a == HALT_A) begin m_phase = 3; m_count = 0; end
         else if (a == END_A) begin
           m_end = ld;
           w = (m_end > m_begin) ? (m_end - m_begin) / 4 : 0;
           m_count = (w > DEPTH) ? DEPTH : int'(w);
           m_mem.delete();
           m_phase = 2;
         end
      2: if (a == HALT_A) m_phase = 3;
         else if (a != BEGIN_A && a != END_A && la >= m_begin && la < m_end && a[1:0] == 2'b00) begin
           w = (la - m_begin) / 4;
           if (w < DEPTH) m_mem[int'(w)] = d;
           else m_ovf = 1'b1;
         end
      default: ;
    endcase
    @(posedge clk);
    #1;
    snoop_we = 1'b0;
  endtask

  // mode 0: ready always high, 1: toggling, 2: random. stop_after < 0 runs to completion.
  task automatic drain(input int mode, input int stop_after, input string tag);
    logic [31:0] exp_q [$];
    int n, got, cyc;
    bit held;
    logic [31:0] hd;
    for (int i = 0; i < m_count; i++) begin
      exp_q.push_back(m_mem.exists(i) ? m_mem[i] : 32'h0);
    end
    n = m_count;
    got = 0;
    cyc = 0;
    held = 1'b0;
    hd = 32'h0;
    check_eq({tag, ".count"}, sig_count, n);
    check_eq({tag, ".ovf"}, overflow, m_ovf);
    check_eq({tag, ".valid_first"}, sig_valid, n > 0);
    while (got < n && got != stop_after && cyc < 8 * DEPTH + 50) begin
      @(negedge clk);
      cyc++;
      case (mode)
        0: sig_ready = 1'b1;
        1: sig_ready = (cyc % 2) == 1;
        default: sig_ready = 1'($urandom_range(0, 1));
      endcase
      if (sig_valid) begin
        if (held) check_eq({tag, ".hold"}, sig_data, hd);
        if (sig_ready) begin
          check_eq($sformatf("%s.beat%0d", tag, got), sig_data, exp_q[got]);
          check_eq($sformatf("%s.last%0d", tag, got), sig_last, got == n - 1);
          got_q.push_back(sig_data);
          got++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          hd = sig_data;
        end
      end
    end
    if (stop_after >= 0) begin
      check_eq({tag, ".partial"}, got, stop_after);
    end else begin
      check_eq({tag, ".beats"}, got, n);
      if (n == 0) begin
        @(negedge clk);
        check_eq({tag, ".done_early"}, done, 1'b0);
      end
      @(negedge clk);
      check_eq({tag, ".done"}, done, 1'b1);
      check_eq({tag, ".valid_end"}, sig_valid, 1'b0);
      sig_ready = 1'b0;
    end
  endtask

  task automatic setup_035();
    wr(BEGIN_A, 32'h4000_0000);
    wr(END_A,   32'h4000_0010);
    wr(32'h4000_0000, 32'h11);
    wr(32'h4000_0004, 32'h22);
    wr(32'h4000_0008, 32'h33);
    wr(32'h4000_000C, 32'h44);
    wr(HALT_A, 32'h0);
  endtask

  initial begin
    logic [31:0] b, e, a;
    int nw;
    rst_n = 1'b0;
    snoop_we = 1'b0;
    snoop_addr = 32'h0;
    snoop_wdat = 32'h0;
    sig_ready = 1'b0;

    do_reset("rst035");
    setup_035();
    drain(0, -1, "t035");
    wr(32'h4000_0000, 32'h99);
    check_eq("t035.after_done", sig_valid, 1'b0);

    do_reset("rst036");
    setup_035();
    drain(1, -1, "t036");

    do_reset("rst037");
    wr(BEGIN_A, 32'h0000_1000);
    wr(END_A, 32'h0000_1000 + 32'(4 * (DEPTH + 2)));
    for (int i = 0; i < DEPTH + 2; i++) wr(32'h0000_1000 + 32'(4 * i), 32'(i * 3 + 7));
    wr(HALT_A, 32'h0);
    drain(2, -1, "t037");

    do_reset("rst038");
    wr(HALT_A, 32'h0);
    drain(0, -1, "t038");

    do_reset("rst039a");
    wr(BEGIN_A, 32'h0000_2000);
    wr(END_A, 32'h0000_2010);
    wr(32'h0000_2008, 32'hAB);
    wr(HALT_A, 32'h0);
    drain(0, -1, "t039a");

    do_reset("rst039b");
    wr(BEGIN_A, 32'h0000_2000);
    wr(END_A, 32'h0000_2010);
    wr(32'h0000_2008, 32'hAB);
    wr(32'h0000_2008, 32'hCD);
    wr(HALT_A, 32'h0);
    drain(2, -1, "t039b");

    do_reset("rstmbx");
    wr(BEGIN_A, 32'h0000_0500);
    wr(END_A, 32'h0000_0520);
    wr(32'h0000_0508, 32'hDEAD);
    wr(32'h0000_050C, 32'hBEEF);
    wr(32'h0000_0510, 32'h5A5A);
    wr(32'h0000_0502, 32'h7777);
    wr(HALT_A, 32'h0);
    drain(0, -1, "tmbx");

    do_reset("rstneg");
    wr(BEGIN_A, 32'h0000_3000);
    wr(END_A, 32'h0000_1000);
    wr(32'h0000_2000, 32'h1);
    wr(HALT_A, 32'h0);
    drain(0, -1, "tneg");

    for (int it = 0; it < 6; it++) begin
      do_reset($sformatf("rstrnd%0d", it));
      b  = 32'h3000_0000 + 32'(4 * $urandom_range(0, 1000));
      nw = $urandom_range(0, DEPTH + 6);
      e  = b + 32'(4 * nw) + 32'($urandom_range(0, 3));
      wr(BEGIN_A, b);
      wr(END_A, e);
      for (int j = 0; j < int'($urandom_range(5, 40)); j++) begin
        a = b + 32'($urandom_range(0, 4 * nw + 8));
        wr(a, $urandom);
      end
      wr(HALT_A, 32'h0);
      drain(2, -1, $sformatf("trnd%0d", it));
    end

    do_reset("rst040");
    setup_035();
    drain(0, 2, "t040a");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t040.async");
    @(negedge clk);
    rst_n = 1'b1;
    sig_ready = 1'b0;
    model_clear();
    @(negedge clk);
    setup_035();
    drain(0, -1, "t040b");
`ifdef SIG_MONITOR_CRC_EN
    check_eq("t040.crc", crc_out, crc_golden());
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
